// File: rtl/rbcla_serial_subtractor.sv
// Multi-cycle unsigned subtractor: D = X - Y evaluated one BLK-bit
// carry look-ahead block per clock, with the block carry held between cycles.

module rbcla_blk #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic [BLK:0]   c
);
  logic [BLK-1:0] g, p;
  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum-of-products over g/p/cin, not a chain.
  always_comb begin
    logic acc, term;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      acc = cin;
      for (int k = 0; k <= i; k++) acc = acc & p[k];
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign s = p ^ c[BLK-1:0];
endmodule

module rbcla_serial_subtractor #(
  parameter int WIDTH = 31,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             busy
);
  localparam int NB   = (WIDTH + BLK - 1) / BLK;
  localparam int LAST = WIDTH - (NB - 1) * BLK;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW   = $clog2(BLK + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] xr, yr, dr;
  logic [BW-1:0]    blk;
  logic             carry, borrow_r;

  logic [31:0]      sh;
  logic [BLK-1:0]   bx, by, s;
  logic [BLK:0]     c;
  logic             last, c_out;
  logic [CW-1:0]    csel;
  logic [WIDTH-1:0] dmask, dnew;

  assign sh   = 32'(blk) * BLK;
  // Right shift zero-fills, so bits past WIDTH-1 in the last block read as 0.
  assign bx   = BLK'(xr >> sh);
  assign by   = BLK'(yr >> sh);
  assign last = (blk == BW'(NB - 1));

  rbcla_blk #(.BLK(BLK)) u_blk (.a(bx), .b(by), .cin(carry), .s(s), .c(c));

  // Final carry comes from bit WIDTH-1, never from the zero padding above it.
  assign csel  = last ? CW'(LAST) : CW'(BLK);
  assign c_out = c[csel];
  assign dmask = WIDTH'({BLK{1'b1}}) << sh;
  assign dnew  = (dr & ~dmask) | (WIDTH'(s) << sh);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr       <= '0;
      yr       <= '0;
      dr       <= '0;
      blk      <= '0;
      carry    <= 1'b0;
      borrow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr    <= x;
          yr    <= ~y;
          carry <= 1'b1;
          blk   <= '0;
        end
        RUN: begin
          dr    <= dnew;
          carry <= c_out;
          if (last) borrow_r <= ~c_out;
          else      blk      <= blk + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign d         = dr;
  assign borrow    = borrow_r;
endmodule

// File: tb/tb_rbcla_serial_subtractor.sv
// Bench for rbcla_serial_subtractor: directed cases on the default build and
// randomized traffic on three parameterizations against an arithmetic model.

module tb_rbcla_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]       iv, ir, ov, ordy, bo, bz;
  logic [2:0][30:0] xv, yv;
  logic [30:0]      d0;
  logic [7:0]       d1;
  logic [9:0]       d2;

  int checks = 0;
  int passes = 0;

  rbcla_serial_subtractor #(.WIDTH(31), .BLK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .x(xv[0]), .y(yv[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .d(d0), .borrow(bo[0]), .busy(bz[0]));

  rbcla_serial_subtractor #(.WIDTH(8), .BLK(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .x(xv[1][7:0]), .y(yv[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .d(d1), .borrow(bo[1]), .busy(bz[1]));

  rbcla_serial_subtractor #(.WIDTH(10), .BLK(3)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .x(xv[2][9:0]), .y(yv[2][9:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .d(d2), .borrow(bo[2]), .busy(bz[2]));

  // Present operands on instance 0 and count edges until out_valid.
  task automatic launch(input logic [30:0] a, input logic [30:0] b, output int lat);
    @(negedge clk);
    iv[0] = 1'b1; xv[0] = a; yv[0] = b;
    @(negedge clk);
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; iv = '0; ordy = '0; xv = '0; yv = '0;
    #3;
    checks++;
    if ({ir[0], ov[0], bz[0], bo[0]} !== 4'b1000 || d0 !== 31'd0)
      $display("FAIL reset: ir/ov/busy/borrow=%b d=%h expected 1000 d=0",
               {ir[0], ov[0], bz[0], bo[0]}, d0);
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    ordy[0] = 1'b1;
    launch(31'd100, 31'd58, lat);
    checks++;
    if (lat !== 8) $display("FAIL basic_latency: got %0d expected 8", lat);
    else passes++;
    checks++;
    if (d0 !== 31'd42 || bo[0] !== 1'b0 || ir[0] !== 1'b0)
      $display("FAIL basic_result: d=%0d borrow=%b ir=%b expected 42 0 0", d0, bo[0], ir[0]);
    else passes++;
    @(negedge clk);
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0)
      $display("FAIL basic_return_idle: ir=%b ov=%b expected 1 0", ir[0], ov[0]);
    else passes++;
  endtask

  task automatic test_full_borrow;
    int lat;
    launch(31'd0, 31'd1, lat);
    checks++;
    if (d0 !== 31'h7FFFFFFF || bo[0] !== 1'b1 || lat !== 8)
      $display("FAIL full_borrow: d=%h borrow=%b lat=%0d expected 7fffffff 1 8", d0, bo[0], lat);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_cross_block;
    int lat;
    launch(31'h40000000, 31'd1, lat);
    checks++;
    if (d0 !== 31'h3FFFFFFF || bo[0] !== 1'b0)
      $display("FAIL cross_block: d=%h borrow=%b expected 3fffffff 0", d0, bo[0]);
    else passes++;
    @(negedge clk);
    launch(31'h7FFFFFFF, 31'h7FFFFFFF, lat);
    checks++;
    if (d0 !== 31'd0 || bo[0] !== 1'b0)
      $display("FAIL equal_max: d=%h borrow=%b expected 0 0", d0, bo[0]);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    ordy[0] = 1'b0;
    launch(31'h10, 31'h1, lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || d0 !== 31'hF || bo[0] !== 1'b0)
        $display("FAIL backpressure_hold[%0d]: ov=%b ir=%b d=%h borrow=%b expected 1 0 f 0",
                 i, ov[0], ir[0], d0, bo[0]);
      else passes++;
      iv[0] = 1'b1; xv[0] = 31'($urandom); yv[0] = 31'($urandom);
      @(negedge clk);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    checks++;
    if (ov[0] !== 1'b1 || d0 !== 31'hF)
      $display("FAIL backpressure_final: ov=%b d=%h expected 1 f", ov[0], d0);
    else passes++;
    @(negedge clk);
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1)
      $display("FAIL backpressure_release: ov=%b ir=%b expected 0 1", ov[0], ir[0]);
    else passes++;
  endtask

  task automatic test_async_reset;
    int lat;
    ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b1; xv[0] = 31'd5; yv[0] = 31'd3;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ir[0], ov[0], bz[0], bo[0]} !== 4'b1000 || d0 !== 31'd0)
      $display("FAIL async_reset: ir/ov/busy/borrow=%b d=%h expected 1000 d=0",
               {ir[0], ov[0], bz[0], bo[0]}, d0);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    launch(31'd7, 31'd9, lat);
    checks++;
    if (d0 !== 31'h7FFFFFFE || bo[0] !== 1'b1 || lat !== 8)
      $display("FAIL after_reset: d=%h borrow=%b lat=%0d expected 7ffffffe 1 8", d0, bo[0], lat);
    else passes++;
    @(negedge clk);
  endtask

  // Random traffic on instance k of width w; model is plain (w+1)-bit subtraction.
  task automatic test_random(input int k, input int w, input int n);
    logic [31:0] mask, exp_v, obs, dk;
    logic        pending;
    int          done, cyc;
    mask = (32'd1 << w) - 32'd1;
    pending = 1'b0; exp_v = '0; done = 0; cyc = 0;
    while (done < n && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      iv[k]   = ($urandom % 3) != 0;
      xv[k]   = 31'($urandom & mask);
      yv[k]   = ($urandom % 8 == 0) ? xv[k] : 31'($urandom & mask);
      ordy[k] = ($urandom % 4) != 0;
      if (iv[k] && ir[k]) begin
        if (pending) begin
          checks++;
          $display("FAIL random%0d_overlap: accepted while result %h outstanding", k, exp_v);
        end
        exp_v = ({1'b0, xv[k]} - {1'b0, yv[k]}) & ((mask << 1) | 32'd1);
        pending = 1'b1;
      end else if (ov[k] && ordy[k]) begin
        case (k)
          0:       dk = {1'b0, d0};
          1:       dk = {24'd0, d1};
          default: dk = {22'd0, d2};
        endcase
        obs = ({31'd0, bo[k]} << w) | dk;
        checks++;
        if (!pending)
          $display("FAIL random%0d_spurious: result %h with nothing accepted", k, obs);
        else if (obs !== exp_v)
          $display("FAIL random%0d_result: got %h expected %h", k, obs, exp_v);
        else passes++;
        pending = 1'b0;
        done++;
      end
    end
    iv[k] = 1'b0;
    checks++;
    if (done < n) $display("FAIL random%0d_timeout: completed %0d of %0d", k, done, n);
    else passes++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full_borrow;
    test_cross_block;
    test_backpressure;
    test_async_reset;
    fork
      test_random(0, 31, 1500);
      test_random(1, 8, 2000);
      test_random(2, 10, 2000);
    join
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
